// File: rtl/lowest_high_scheduler.sv
// Sticky-pending request scheduler issuing one grant at a time over valid/ready.
// Selection is lowest-index fixed priority, or round-robin starting above the last grant.
module lowest_high_scheduler #(
  parameter int unsigned N   = 128,
  parameter int unsigned IDW = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_set,
  input  logic [N-1:0]   req_mask,
  input  logic           rr_en,
  input  logic           flush,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  input  logic           gnt_ready,
  output logic [N-1:0]   pending,
  output logic           any_eligible
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] last_id_q, last_id_d;

  logic [N-1:0]   eligible;
  logic [N-1:0]   eligible_hi;
  logic [N-1:0]   acc_clr;
  logic [IDW-1:0] rr_start;
  logic [IDW-1:0] sel;
  logic           accept;

  function automatic logic [IDW-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  assign eligible     = pending_q & req_mask;
  assign any_eligible = |eligible;
  assign gnt_valid    = (state_q == StGrant);
  assign gnt_id       = gnt_id_q;
  assign pending      = pending_q;
  assign accept       = gnt_valid & gnt_ready;

  // Round-robin starts one above the last grant; last_id = N-1 wraps to 0.
  always_comb begin
    rr_start = (last_id_q == IDW'(N - 1)) ? '0 : last_id_q + 1'b1;
    for (int i = 0; i < N; i++) begin
      eligible_hi[i] = eligible[i] & (i >= int'(rr_start));
    end
    if (rr_en && (|eligible_hi)) begin
      sel = lowest_idx(eligible_hi);
    end else begin
      sel = lowest_idx(eligible);
    end
  end

  always_comb begin
    acc_clr = '0;
    if (accept) acc_clr[gnt_id_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    pending_d = (pending_q & ~acc_clr) | req_set;
    if (flush) begin
      // Flush drops the offered grant and any coincident handshake.
      pending_d = req_set;
      state_d   = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_eligible) begin
            gnt_id_d = sel;
            state_d  = StGrant;
          end
        end
        StGrant: begin
          if (gnt_ready) begin
            last_id_d = gnt_id_q;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      gnt_id_q  <= '0;
      last_id_q <= IDW'(N - 1);
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
    end
  end

endmodule
